fifo_wr_arbiter: RTL and testbench
==================================

Name: fifo_wr_arbiter

Overview:
Round-robin burst arbiter that shares the single write port of a synchronous-mode FIFO_CORE instance (66-bit, 512-deep) between NUM_REQ block producers on the raw 10G link datapath, such as per-lane 64b/66b framers.
- A grant is held for a whole burst, so each producer's blocks land contiguously in the FIFO.
- The arbiter honours the FIFO full and almost_full flags.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
DATA_WIDTH, 66, width of one block/FIFO word
BURST_MAX, 16, maximum beats per grant (1..256)
ID_W, 2, grant index width, ceil(log2(NUM_REQ)) (1 when NUM_REQ=2)

Ports:
clk  in  1  single clock; FIFO wr_clk is tied to the same clock
rst_n  in  1  asynchronous active-low reset
req_valid  in  NUM_REQ  per-requester word valid
req_last  in  NUM_REQ  marks the final word of the requester's burst
req_data  in  NUM_REQ*DATA_WIDTH  requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
req_ready  out  NUM_REQ  per-requester accept; a word transfers when valid & ready
fifo_wr_data  out  DATA_WIDTH  to FIFO wr_data
fifo_wr_en  out  1  to FIFO wr_en
fifo_wr_full  in  1  from FIFO wr_full
fifo_almost_full  in  1  from FIFO almost_full
grant_id  out  ID_W  index of the current/last granted requester
busy  out  1  high in states GRANT and XFER
stall_cnt  out  16  saturating count of full-stall cycles

Behaviour:
- Reset values: grant_id=0, req_ready=0, fifo_wr_en=0, fifo_wr_data=0, busy=0, stall_cnt=0, state=IDLE, beat_cnt=0, rr_ptr=0.
- State IDLE:
  - Go to GRANT when any req_valid is high and fifo_almost_full=0.
  - While fifo_almost_full=1, stay in IDLE; no new grant is issued.
- State GRANT (1 cycle, registered):
  - Select the first requester with req_valid=1, searching from rr_ptr upward with wrap-around.
  - Latch the winner into grant_id, clear beat_cnt, go to XFER.
  - If no request remains (valid withdrawn), return to IDLE.
- State XFER:
  - req_ready[grant_id] = ~fifo_wr_full; all other req_ready bits are 0.
  - fifo_wr_en = req_valid[grant_id] & ~fifo_wr_full.
  - fifo_wr_data = req_data slice of grant_id. This is a combinational path: zero-cycle latency, and no word is ever presented while full.
  - fifo_wr_data is held at its last written value when fifo_wr_en=0.
  - Each transfer increments beat_cnt.
  - fifo_almost_full does not interrupt an active burst; only fifo_wr_full stalls it.
  - The burst ends on the transfer that carries req_last=1, or when beat_cnt reaches BURST_MAX-1 on a transfer. On burst end: rr_ptr = grant_id+1 (wrapping at NUM_REQ), go to IDLE.
  - A requester dropping valid mid-burst does not release the grant; the grant is held until the burst ends.
- Arbitration overhead: 2 cycles between bursts (XFER→IDLE→GRANT). Back-to-back throughput is BURST_MAX/(BURST_MAX+2).
- stall_cnt increments in any XFER cycle where req_valid[grant_id]=1 and fifo_wr_full=1. It saturates at 0xFFFF and clears only on reset.
- Simultaneous req_last and BURST_MAX on the same beat: a single burst end, with no double pointer advance.
- fifo_wr_full rising on the same cycle a word is presented: the word is not taken (ready=0) and stays pending at the requester.
- Asynchronous reset mid-burst: immediate return to reset values. The partially written burst stays in the FIFO; the FIFO is reset from the same source.
- Requester data bits outside the granted slice are ignored; X on non-granted inputs must not propagate.

Test Plan:
1. Single requester 2, 5-word burst with req_last on beat 5, FIFO empty → grant_id=2 two cycles after valid; 5 consecutive fifo_wr_en pulses with matching data; busy drops; rr_ptr=3.
2. All 4 requesters valid continuously, bursts without last, BURST_MAX=16 → grants cycle 0,1,2,3,0; each burst exactly 16 writes; 2 idle cycles between bursts; FIFO read-back order matches.
3. fifo_wr_full forced high for 7 cycles mid-burst (after beat 3) → fifo_wr_en=0 and req_ready=0 for those cycles; stall_cnt=7; beats 4..16 then written with no loss or duplication.
4. fifo_almost_full=1 while requesters 0 and 1 are valid in IDLE → no grant and busy=0; deassert → grant to requester 0 within 1 cycle of GRANT entry. Then assert almost_full mid-burst → the burst completes all beats.
5. Requester 1 drops valid for 4 cycles mid-burst while requester 3 is valid → grant_id stays 1, no writes from 3, burst resumes and ends on last.
6. rst_n pulsed low during beat 6 of a burst → all outputs at reset values asynchronously; after release, the first grant goes to requester 0 (rr_ptr=0) if valid.

Source files
------------

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter
// Round-robin burst arbiter sharing one FIFO write port between NUM_REQ
// block producers. A grant is held for a whole burst (until req_last or
// BURST_MAX beats), so each producer's words land contiguously.
//
// Ports:
//   clk, rst_n        single clock, asynchronous active-low reset
//   req_valid/last    per-requester word valid and end-of-burst marker
//   req_data          requester i at bits [i*DATA_WIDTH +: DATA_WIDTH]
//   req_ready         per-requester accept (word moves on valid & ready)
//   fifo_wr_data/en   to FIFO write port (combinational from granted slice)
//   fifo_wr_full      stalls an active burst
//   fifo_almost_full  blocks new grants only
//   grant_id          current/last granted requester
//   busy              high in GRANT and XFER
//   stall_cnt         saturating count of full-stall cycles
module fifo_wr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 66,
  parameter int BURST_MAX  = 16,
  parameter int ID_W       = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0]            req_last,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [DATA_WIDTH-1:0]         fifo_wr_data,
  output logic                          fifo_wr_en,
  input  logic                          fifo_wr_full,
  input  logic                          fifo_almost_full,
  output logic [ID_W-1:0]               grant_id,
  output logic                          busy,
  output logic [15:0]                   stall_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    XFER  = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [ID_W-1:0]       grant_id_q, grant_id_d;
  logic [ID_W-1:0]       rr_ptr_q, rr_ptr_d;
  logic [8:0]            beat_cnt_q, beat_cnt_d;
  logic                  busy_q, busy_d;
  logic [15:0]           stall_cnt_q, stall_cnt_d;
  logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;

  logic [DATA_WIDTH-1:0] gnt_data;
  logic                  gnt_valid;
  logic                  gnt_last;
  logic                  xfer;
  logic                  take;
  logic                  burst_end;
  logic                  found;
  logic [ID_W-1:0]       win;

  // Select the granted requester's signals with constant indices only, so
  // X on non-granted inputs never reaches the outputs.
  always_comb begin
    gnt_data  = '0;
    gnt_valid = 1'b0;
    gnt_last  = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant_id_q == ID_W'(i)) begin
        gnt_data  = req_data[i*DATA_WIDTH +: DATA_WIDTH];
        gnt_valid = req_valid[i];
        gnt_last  = req_last[i];
      end
    end
  end

  // First valid requester at or after rr_ptr, wrapping at NUM_REQ.
  always_comb begin
    int unsigned     s;
    logic [ID_W-1:0] idx;
    found = 1'b0;
    win   = '0;
    s     = 0;
    idx   = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      s = 32'(rr_ptr_q) + k;
      if (s >= 32'(NUM_REQ)) s = s - 32'(NUM_REQ);
      idx = ID_W'(s);
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  assign xfer      = (state_q == XFER);
  assign take      = xfer && gnt_valid && !fifo_wr_full;
  assign burst_end = take && (gnt_last || (beat_cnt_q == 9'(BURST_MAX-1)));

  always_comb begin
    req_ready = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      req_ready[i] = xfer && (grant_id_q == ID_W'(i)) && !fifo_wr_full;
    end
  end

  // Data passes straight through on a write; otherwise the last written
  // word is held.
  assign fifo_wr_en   = take;
  assign fifo_wr_data = take ? gnt_data : wr_data_q;

  always_comb begin
    state_d     = state_q;
    grant_id_d  = grant_id_q;
    rr_ptr_d    = rr_ptr_q;
    beat_cnt_d  = beat_cnt_q;
    stall_cnt_d = stall_cnt_q;
    wr_data_d   = take ? gnt_data : wr_data_q;
    case (state_q)
      IDLE: begin
        if ((|req_valid) && !fifo_almost_full) state_d = GRANT;
      end
      GRANT: begin
        if (found) begin
          grant_id_d = win;
          beat_cnt_d = '0;
          state_d    = XFER;
        end else begin
          state_d = IDLE;
        end
      end
      XFER: begin
        if (gnt_valid && fifo_wr_full && (stall_cnt_q != '1))
          stall_cnt_d = stall_cnt_q + 16'd1;
        if (take) beat_cnt_d = beat_cnt_q + 9'd1;
        // last and BURST_MAX on the same beat form one end event
        if (burst_end) begin
          rr_ptr_d = (grant_id_q == ID_W'(NUM_REQ-1)) ? '0 : grant_id_q + 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      grant_id_q  <= '0;
      rr_ptr_q    <= '0;
      beat_cnt_q  <= '0;
      busy_q      <= 1'b0;
      stall_cnt_q <= '0;
      wr_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      grant_id_q  <= grant_id_d;
      rr_ptr_q    <= rr_ptr_d;
      beat_cnt_q  <= beat_cnt_d;
      busy_q      <= busy_d;
      stall_cnt_q <= stall_cnt_d;
      wr_data_q   <= wr_data_d;
    end
  end

  assign grant_id  = grant_id_q;
  assign busy      = busy_q;
  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter. Producers are queues of words;
// the expected FIFO write order is derived from the round-robin burst rules.
module tb_fifo_wr_arbiter;
  localparam int NR = 4;
  localparam int DW = 66;
  localparam int BM = 16;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [NR-1:0]    req_valid, req_last, req_ready;
  logic [NR*DW-1:0] req_data;
  logic [DW-1:0]    fifo_wr_data;
  logic             fifo_wr_en, fifo_wr_full, fifo_almost_full;
  logic [1:0]       grant_id;
  logic             busy;
  logic [15:0]      stall_cnt;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] wq [NR][$];
  bit            lq [NR][$];
  bit            en [NR];
  logic [DW-1:0] got_q[$];
  logic [DW-1:0] exp_q[$];
  int            wcyc[$];
  int            cyc  = 0;
  int            mptr = 0;
  int            seqn = 0;
  logic [NR-1:0] xfer_pend;
  logic          full_n, af_n;

  always #5 clk = ~clk;

  fifo_wr_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .BURST_MAX(BM), .ID_W(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_last(req_last), .req_data(req_data),
    .req_ready(req_ready),
    .fifo_wr_data(fifo_wr_data), .fifo_wr_en(fifo_wr_en),
    .fifo_wr_full(fifo_wr_full), .fifo_almost_full(fifo_almost_full),
    .grant_id(grant_id), .busy(busy), .stall_cnt(stall_cnt)
  );

  task automatic chk(string tag, logic [DW-1:0] obs, logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int pending();
    int s = 0;
    for (int i = 0; i < NR; i++) s += wq[i].size();
    return s;
  endfunction

  task automatic drive();
    for (int i = 0; i < NR; i++) begin
      req_valid[i] = en[i] && (wq[i].size() > 0);
      req_last[i]  = (wq[i].size() > 0) ? lq[i][0] : 1'bx;
      req_data[i*DW +: DW] = (wq[i].size() > 0) ? wq[i][0] : {DW{1'bx}};
    end
  endtask

  // One cycle: apply next-cycle inputs after the edge, sample at negedge.
  task automatic step();
    @(posedge clk); #1;
    cyc++;
    for (int i = 0; i < NR; i++)
      if (xfer_pend[i]) begin
        void'(wq[i].pop_front());
        void'(lq[i].pop_front());
      end
    fifo_wr_full     = full_n;
    fifo_almost_full = af_n;
    drive();
    @(negedge clk);
    chk("no_write_while_full", fifo_wr_en & fifo_wr_full, 0);
    chk("ready_onehot", $countones(req_ready) <= 1, 1);
    chk("ready_only_busy", (req_ready != 0) && !busy, 0);
    chk("wr_data_known", $isunknown(fifo_wr_data), 0);
    if (fifo_wr_en) begin
      got_q.push_back(fifo_wr_data);
      wcyc.push_back(cyc);
    end
    xfer_pend = req_valid & req_ready;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_wr_en", fifo_wr_en, 0);
    chk("rst_ready", req_ready, 0);
    chk("rst_wr_data", fifo_wr_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_grant", grant_id, 0);
    chk("rst_stall", stall_cnt, 0);
    xfer_pend = '0;
    mptr = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    full_n = 1'b0; af_n = 1'b0;
    fifo_wr_full = 1'b0; fifo_almost_full = 1'b0;
    drive();
    @(negedge clk);
  endtask

  task automatic load(int id, int n, int lastp);
    for (int k = 0; k < n; k++) begin
      wq[id].push_back({4'(id), 16'(seqn), 46'({$urandom(), $urandom()})});
      seqn++;
      lq[id].push_back((k == n-1) || (lastp > 0 && $urandom_range(0, lastp-1) == 0));
    end
  endtask

  task automatic clr();
    got_q.delete(); exp_q.delete(); wcyc.delete();
  endtask

  // Round-robin burst model, assuming every producer with words stays valid.
  task automatic predict();
    int  pos [NR];
    int  p, j, n;
    bit  any, lastf;
    for (int i = 0; i < NR; i++) pos[i] = 0;
    p = mptr;
    forever begin
      any = 0; j = 0;
      for (int k = 0; k < NR; k++)
        if (!any && pos[(p+k)%NR] < wq[(p+k)%NR].size()) begin
          any = 1; j = (p+k)%NR;
        end
      if (!any) break;
      n = 0;
      do begin
        exp_q.push_back(wq[j][pos[j]]);
        lastf = lq[j][pos[j]];
        pos[j]++; n++;
      end while (!lastf && n < BM);
      p = (j+1) % NR;
    end
    mptr = p;
  endtask

  task automatic drain(string tag, int maxc);
    int n = 0;
    while ((pending() > 0 || busy) && n < maxc) begin step(); n++; end
    chk({tag, "_drain_timeout"}, n < maxc, 1);
  endtask

  task automatic wait_writes(string tag, int cnt, int maxc);
    int n = 0;
    while (got_q.size() < cnt && n < maxc) begin step(); n++; end
    chk({tag, "_wait_timeout"}, n < maxc, 1);
  endtask

  task automatic compare(string tag);
    chk({tag, "_count"}, got_q.size(), exp_q.size());
    for (int k = 0; k < got_q.size() && k < exp_q.size(); k++)
      chk($sformatf("%s_word%0d", tag, k), got_q[k], exp_q[k]);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b1;
    req_valid = '0; req_last = '0; req_data = '0;
    fifo_wr_full = 1'b0; fifo_almost_full = 1'b0;
    full_n = 1'b0; af_n = 1'b0; xfer_pend = '0;
    for (int i = 0; i < NR; i++) en[i] = 1'b1;
    #2;
    do_reset();

    // 1: single requester 2, five words
    clr(); load(2, 5, 0); predict();
    step(); chk("t1_idle_busy", busy, 0);
    step(); chk("t1_grant_busy", busy, 1);
    chk("t1_grant_not_yet", fifo_wr_en, 0);
    step(); chk("t1_grant_id", grant_id, 2);
    chk("t1_first_wr", fifo_wr_en, 1);
    for (int k = 0; k < 4; k++) begin step(); chk($sformatf("t1_wr%0d", k+2), fifo_wr_en, 1); end
    step(); chk("t1_busy_drop", busy, 0);
    chk("t1_wr_stop", fifo_wr_en, 0);
    drain("t1", 20); compare("t1");
    // pointer now 3: requester 3 must win over 0
    clr(); load(0, 2, 0); load(3, 2, 0); predict();
    drain("t1rr", 40); compare("t1rr");

    // 2: all four continuously valid, 20 words each (16 + 4)
    do_reset(); clr();
    for (int i = 0; i < NR; i++) load(i, 20, 0);
    predict();
    drain("t2", 400); compare("t2");
    for (int k = 0; k + 1 < wcyc.size() && k < 79; k++)
      chk($sformatf("t2_gap%0d", k), wcyc[k+1] - wcyc[k],
          ((k < 64) ? (k % 16 == 15) : ((k - 64) % 4 == 3)) ? 3 : 1);

    // 3: full for 7 cycles after beat 3; beat 16 carries last as well
    do_reset(); clr();
    load(0, 16, 0); load(1, 2, 0); load(2, 2, 0); predict();
    wait_writes("t3", 3, 20);
    full_n = 1'b1;
    for (int k = 0; k < 7; k++) begin
      step();
      chk("t3_full_wr_en", fifo_wr_en, 0);
      chk("t3_full_ready", req_ready, 0);
    end
    full_n = 1'b0;
    drain("t3", 100);
    chk("t3_stall_cnt", stall_cnt, 7);
    compare("t3");

    // 4: almost_full blocks grants but not an active burst
    do_reset(); clr();
    load(0, 6, 0); load(1, 3, 0); predict();
    af_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step(); chk("t4_af_busy", busy, 0); chk("t4_af_wr", fifo_wr_en, 0);
    end
    af_n = 1'b0;
    step(); chk("t4_rel_idle", busy, 0);
    step(); chk("t4_rel_grant", busy, 1);
    step(); chk("t4_grant_id", grant_id, 0); chk("t4_first_wr", fifo_wr_en, 1);
    step(); af_n = 1'b1;
    for (int n = 0; n < 40 && wq[0].size() > 0; n++) step();
    for (int k = 0; k < 3; k++) begin step(); chk("t4_af_hold", busy, 0); end
    chk("t4_burst_done", got_q.size(), 6);
    af_n = 1'b0;
    drain("t4", 60); compare("t4");

    // 5: requester 1 drops valid mid-burst, requester 3 waiting
    do_reset(); clr();
    load(1, 10, 0); load(3, 4, 0); predict();
    wait_writes("t5", 3, 20);
    en[1] = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step(); chk("t5_hold_grant", grant_id, 1); chk("t5_no_wr", fifo_wr_en, 0);
    end
    en[1] = 1'b1;
    drain("t5", 80);
    chk("t5_stall", stall_cnt, 0);
    compare("t5");

    // 6: reset during beat 6 of a burst from requester 1 (pointer was 3)
    do_reset(); clr();
    load(2, 5, 0); predict();
    drain("t6a", 40); compare("t6a");
    clr(); load(1, 10, 0);
    wait_writes("t6", 5, 20);
    load(0, 3, 0); load(3, 3, 0);
    step();
    chk("t6_pre_grant", grant_id, 1);
    chk("t6_pre_wr", fifo_wr_en, 1);
    do_reset(); clr(); predict();
    drain("t6", 120); compare("t6");
    chk("t6_first_req0", got_q.size() > 0 ? got_q[0][65:62] : 4'hf, 0);

    // randomized rounds: random lengths, last flags, full and almost_full
    for (int r = 0; r < 4; r++) begin
      int n = 0;
      clr();
      for (int i = 0; i < NR; i++) load(i, $urandom_range(0, 30), 5);
      predict();
      while ((pending() > 0 || busy) && n < 3000) begin
        full_n = ($urandom_range(0, 7) == 0);
        af_n   = ($urandom_range(0, 3) == 0);
        step(); n++;
      end
      chk($sformatf("rnd%0d_timeout", r), n < 3000, 1);
      full_n = 1'b0; af_n = 1'b0;
      compare($sformatf("rnd%0d", r));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
